// File: rtl/timer_counter_pkg.sv
// Shared types and constants for the timer_counter block: FSM state encoding,
// count-direction constants and a small state-decode helper.
package timer_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // True only for the counting state; used to gate the prescaler.
    function automatic logic is_running(input state_t st);
        logic run_v;
        case (st)
            ST_RUN:  run_v = 1'b1;
            ST_IDLE: run_v = 1'b0;
            ST_DONE: run_v = 1'b0;
            default: run_v = 1'b0;
        endcase
        return run_v;
    endfunction

endpackage

// File: rtl/timer_counter_prescaler.sv
// Tick divider for timer_counter: asserts tick once every presc+1 enabled clocks.
// Only instantiated when TIMER_COUNTER_PRESCALE_EN is defined.
module timer_counter_prescaler
    import timer_counter_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] presc,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] CNT_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] CNT_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] cnt_r;

    // The owner ignores tick whenever a higher-priority command is present,
    // so tick need not be masked by clear here.
    assign tick = enable && (cnt_r == presc);

    // Divider count: restarts on clear and whenever the timer is not counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (clear || !enable) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r == presc) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// timer_counter: start/stop counter with up/down, one-shot/periodic, mid-run load
// and a one-cycle terminal pulse. Optional prescaler via TIMER_COUNTER_PRESCALE_EN.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef TIMER_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE_W = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode_down,
    input  logic                  oneshot,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
`ifdef TIMER_COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] presc,
`endif
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic                  done
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    logic             busy_r;
    logic             done_r;
    logic             down_r;
    logic             oneshot_r;
    logic [WIDTH-1:0] lim_r;

    logic             tick_s;
    logic             at_term_s;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] reload_s;

`ifdef TIMER_COUNTER_PRESCALE_EN
    logic presc_clr_s;
    logic presc_en_s;

    assign presc_clr_s = clr | load | start;
    assign presc_en_s  = is_running(state_r);

    timer_counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (presc_clr_s),
        .enable (presc_en_s),
        .presc  (presc),
        .tick   (tick_s)
    );
`else
    assign tick_s = 1'b1;
`endif

    // Terminal detect and next-count candidates for the latched direction
    always_comb begin
        at_term_s = 1'b0;
        step_s    = q_r;
        reload_s  = q_r;
        if (down_r == MODE_DOWN) begin
            at_term_s = (q_r == ZERO_W);
            step_s    = q_r - ONE_W;
            reload_s  = lim_r;
        end else begin
            // Equality only: a loaded value above the limit wraps through zero.
            at_term_s = (q_r == lim_r);
            step_s    = q_r + ONE_W;
            reload_s  = ZERO_W;
        end
    end

    // Control FSM with priority clr > load > start > stop > tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            q_r       <= ZERO_W;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            down_r    <= MODE_UP;
            oneshot_r <= 1'b0;
            lim_r     <= ZERO_W;
        end else if (clr) begin
            state_r <= ST_IDLE;
            q_r     <= ZERO_W;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (load) begin
            q_r    <= load_val;
            done_r <= 1'b0;
        end else if (start) begin
            down_r    <= mode_down;
            oneshot_r <= oneshot;
            lim_r     <= limit;
            q_r       <= (mode_down == MODE_UP) ? ZERO_W : limit;
            state_r   <= ST_RUN;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (tick_s) begin
                        if (at_term_s) begin
                            done_r <= 1'b1;
                            if (oneshot_r) begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                            end else begin
                                q_r <= reload_s;
                            end
                        end else begin
                            q_r <= step_s;
                        end
                    end else begin
                        q_r <= q_r;
                    end
                end
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: recover to a safe idle state.
                    state_r <= ST_IDLE;
                    q_r     <= ZERO_W;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = q_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus random stimulus
// compared every cycle against a behavioural model of the counter.
module tb_timer_counter;

    localparam int MODV = 256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, start, stop, mode_down, oneshot, load;
    logic [7:0] limit, load_val;
    logic [7:0] presc_v;
    logic [7:0] q;
    logic       busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    int m_q, m_lim, m_pcnt;
    bit m_run, m_down, m_one, m_done;

    always #5 clk = ~clk;

    timer_counter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .start     (start),
        .stop      (stop),
        .mode_down (mode_down),
        .oneshot   (oneshot),
        .limit     (limit),
        .load      (load),
        .load_val  (load_val),
`ifdef TIMER_COUNTER_PRESCALE_EN
        .presc     (presc_v),
`endif
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_lim = 0; m_pcnt = 0;
        m_run = 0; m_down = 0; m_one = 0; m_done = 0;
    endtask

    // One clock of the specified behaviour, using the inputs present at the edge.
    task automatic model_step();
        int pv;
        bit tick;
        bit term;
`ifdef TIMER_COUNTER_PRESCALE_EN
        pv = int'(presc_v);
`else
        pv = 0;
`endif
        m_done = 1'b0;
        if (clr) begin
            m_run = 0; m_q = 0; m_pcnt = 0;
        end else if (load) begin
            m_q = int'(load_val); m_pcnt = 0;
        end else if (start) begin
            m_down = mode_down; m_one = oneshot; m_lim = int'(limit);
            m_q = mode_down ? m_lim : 0;
            m_run = 1; m_pcnt = 0;
        end else if (stop && m_run) begin
            m_run = 0; m_pcnt = 0;
        end else if (m_run) begin
            tick = (m_pcnt == pv);
            m_pcnt = tick ? 0 : (m_pcnt + 1) % 256;
            if (tick) begin
                term = m_down ? (m_q == 0) : (m_q == m_lim);
                if (term) begin
                    m_done = 1'b1;
                    if (m_one) m_run = 0;
                    else       m_q = m_down ? m_lim : 0;
                end else begin
                    m_q = m_down ? m_q - 1 : (m_q + 1) % MODV;
                end
            end
        end
    endtask

    // Advance one clock, update the model and compare all outputs after the edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("q", {24'd0, q}, m_q);
        check("busy", {31'd0, busy}, {31'd0, m_run});
        check("done", {31'd0, done}, {31'd0, m_done});
    endtask

    task automatic idle_inputs();
        clr = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    endtask

    task automatic do_start(input logic dn, input logic os, input logic [7:0] lim);
        mode_down = dn; oneshot = os; limit = lim; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int k_done;
        int n_done;
        int q_at_done;
        rst_n = 1'b0;
        idle_inputs();
        mode_down = 1'b0; oneshot = 1'b0; limit = 8'd0; load_val = 8'd0; presc_v = 8'd0;
        model_reset();
        #3;
        check("reset_q", {24'd0, q}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Up, one-shot, limit 5: done 6 clocks after start, then held at 5.
        do_start(1'b0, 1'b1, 8'd5);
        check("up_start_q", {24'd0, q}, 32'd0);
        check("up_start_busy", {31'd0, busy}, 32'd1);
        k_done = -1; n_done = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (done === 1'b1) begin
                n_done++;
                if (k_done < 0) k_done = k;
            end
        end
        check("oneshot_done_cycle", k_done, 32'd6);
        check("oneshot_done_count", n_done, 32'd1);
        check("oneshot_hold_q", {24'd0, q}, 32'd5);
        check("oneshot_busy", {31'd0, busy}, 32'd0);

        // Down, periodic, limit 3: done every 4 clocks, busy stays high.
        do_start(1'b1, 1'b0, 8'd3);
        check("down_start_q", {24'd0, q}, 32'd3);
        n_done = 0; k_done = -1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (done === 1'b1) begin
                n_done++;
                if (k_done < 0) k_done = k;
                check("down_done_phase", k % 4, 32'd0);
            end
        end
        check("down_done_count", n_done, 32'd3);
        check("down_first_done", k_done, 32'd4);
        check("down_busy", {31'd0, busy}, 32'd1);

        // Stop at q=4, then restart from 0.
        do_start(1'b0, 1'b0, 8'd10);
        repeat (4) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("stop_q", {24'd0, q}, 32'd4);
        check("stop_busy", {31'd0, busy}, 32'd0);
        repeat (3) cyc();
        check("stop_hold_q", {24'd0, q}, 32'd4);
        do_start(1'b0, 1'b0, 8'd10);
        check("restart_q", {24'd0, q}, 32'd0);

        // Load 200 at q=7 with limit 9: wraps silently, done 66 clocks after load.
        do_start(1'b0, 1'b0, 8'd9);
        repeat (7) cyc();
        check("pre_load_q", {24'd0, q}, 32'd7);
        load = 1'b1; load_val = 8'd200;
        cyc();
        load = 1'b0;
        check("load_q", {24'd0, q}, 32'd200);
        k_done = -1; q_at_done = -1;
        for (int k = 1; k <= 80; k++) begin
            cyc();
            if (done === 1'b1 && k_done < 0) begin
                k_done = k;
                q_at_done = int'(q);
            end
        end
        check("wrap_done_cycle", k_done, 32'd66);
        check("wrap_q_at_done", q_at_done, 32'd0);

        // clr and start together while running: clr wins.
        repeat (3) cyc();
        clr = 1'b1; start = 1'b1; limit = 8'd20;
        cyc();
        idle_inputs();
        check("clr_start_q", {24'd0, q}, 32'd0);
        check("clr_start_busy", {31'd0, busy}, 32'd0);
        check("clr_start_done", {31'd0, done}, 32'd0);

        // Asynchronous reset mid-count clears outputs without waiting for a clock.
        do_start(1'b0, 1'b0, 8'd50);
        repeat (5) cyc();
        rst_n = 1'b0;
        #1;
        check("async_rst_q", {24'd0, q}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc();

`ifdef TIMER_COUNTER_PRESCALE_EN
        // presc=2, up one-shot limit 2: step every 3 clocks, done 9 clocks after start.
        presc_v = 8'd2;
        do_start(1'b0, 1'b1, 8'd2);
        k_done = -1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            if (k == 3) check("presc_first_step", {24'd0, q}, 32'd1);
            if (done === 1'b1 && k_done < 0) k_done = k;
        end
        check("presc_done_cycle", k_done, 32'd9);
        presc_v = 8'd0;
`endif

        // Random phase against the model.
        for (int i = 0; i < 800; i++) begin
            clr       = ($urandom_range(0, 39) == 0);
            load      = ($urandom_range(0, 19) == 0);
            start     = ($urandom_range(0, 11) == 0);
            stop      = ($urandom_range(0, 29) == 0);
            mode_down = $urandom_range(0, 1) != 0;
            oneshot   = $urandom_range(0, 2) == 0;
            limit     = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            load_val  = 8'($urandom);
`ifdef TIMER_COUNTER_PRESCALE_EN
            if (start) presc_v = 8'($urandom_range(0, 3));
`endif
            cyc();
        end
        idle_inputs();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
